mult_hilo_ctrl: RTL and testbench

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

---
 rtl/mult_pkg.sv | 15 +
 rtl/hilo_regs.sv | 31 +++
 rtl/mult_hilo_ctrl.sv | 118 +++++++++++
 tb/tb_mult_hilo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, timeout default and FSM encoding for the HI/LO multiply controller
package mult_pkg;

    localparam int DATA_W          = 32;
    localparam int TIMEOUT_DEFAULT = 48;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - architectural HI/LO registers with multiplier capture vs. direct write select
module hilo_regs
    import mult_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_hi,
    input  logic [DATA_W-1:0] cap_lo,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    // Capture of a multiplier result wins; otherwise each half takes its own direct write.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (capture) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - multiply sequencer with watchdog driving an external iterative multiplier
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] mult_a,
    output logic [DATA_W-1:0] mult_b,
    output logic              mult_init,
    output logic              mult_run,
    input  logic              mult_done,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int             WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t          state;
    state_t          next_state;
    logic [WD_W-1:0] watchdog;
    logic            accept;
    logic            capture;
    logic            init_d;
    logic            run_d;
    logic            busy_d;
    logic            done_d;
    logic            error_d;

    assign accept  = (state == S_IDLE) && start;
    assign capture = (state == S_RUN) && mult_done;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state: mult_done only matters in RUN, and a result on the timeout cycle still wins.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_INIT;
            S_INIT:  next_state = S_RUN;
            S_RUN:   if (mult_done)              next_state = S_DONE;
                     else if (watchdog == WD_MAX) next_state = S_ERR;
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with the state they describe.
    always_comb begin
        init_d  = (next_state == S_INIT);
        run_d   = (next_state == S_RUN);
        busy_d  = (next_state != S_IDLE);
        done_d  = (next_state == S_DONE);
        error_d = error;
        if (next_state == S_ERR) error_d = 1'b1;
        else if (accept)         error_d = 1'b0;
    end

    // Output registers, operand latch and RUN-cycle watchdog (1 in the first RUN cycle).
    always_ff @(posedge clock) begin
        if (reset) begin
            mult_init <= 1'b0;
            mult_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
            watchdog  <= '0;
        end else begin
            mult_init <= init_d;
            mult_run  <= run_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            if (accept) begin
                mult_a <= op_a;
                mult_b <= op_b;
            end
            if (next_state == S_RUN)
                watchdog <= (state == S_RUN) ? watchdog + WD_W'(1) : WD_W'(1);
            else
                watchdog <= '0;
        end
    end

    hilo_regs u_hilo_regs (
        .clock   (clock),
        .reset   (reset),
        .capture (capture),
        .cap_hi  (mult_hi),
        .cap_lo  (mult_lo),
        .wr_hi   ((state == S_IDLE) && mthi),
        .wr_lo   ((state == S_IDLE) && mtlo),
        .wdata   (wdata),
        .hi      (hi_out),
        .lo      (lo_out)
    );

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - scoreboard bench for mult_hilo_ctrl with a behavioural iterative multiplier
module tb_mult_hilo_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [31:0] mult_a, mult_b;
    logic        mult_init, mult_run;
    logic        mult_done;
    logic [31:0] mult_hi, mult_lo;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, error;

    mult_hilo_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init), .mult_run(mult_run),
        .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // Multiplier model: answers in its lat-th RUN cycle unless hung; drives noise whenever not running.
    int          lat  = 34;
    bit          hang = 1'b0;
    int          cnt  = 0;
    logic [63:0] prod = '0;
    logic        noise_done = 1'b0;
    logic [31:0] noise_hi = '0, noise_lo = '0;

    always @(posedge clock) begin
        noise_done <= 1'($urandom_range(0, 1));
        noise_hi   <= $urandom;
        noise_lo   <= $urandom;
        if (mult_init) begin
            cnt  <= 0;
            prod <= longint'($signed(mult_a)) * longint'($signed(mult_b));
        end else if (mult_run) begin
            cnt <= cnt + 1;
        end
    end

    assign mult_done = mult_run ? (!hang && cnt == lat - 1) : noise_done;
    assign mult_hi   = (mult_run && mult_done) ? prod[63:32] : noise_hi;
    assign mult_lo   = (mult_run && mult_done) ? prod[31:0]  : noise_lo;

    typedef struct {
        bit          is_err;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [31:0] model_hi = '0, model_lo = '0;
    logic [31:0] exp_a = '0, exp_b = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (busy) check("mult_ab_stable", {mult_a, mult_b}, {exp_a, exp_b});
            if (done || (busy && error)) begin
                if (done) done_cnt++;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_completion: got done=%0b error=%0b expected nothing pending", done, error);
                end else begin
                    e = sbq.pop_front();
                    check("completion_kind", 64'(error), 64'(e.is_err));
                    check("completion_hilo", {hi_out, lo_out}, {e.hi, e.lo});
                end
            end
        end
    endtask

    // One multiply; inj>0 pulses start/mthi/mtlo while busy at that edge count; wr_same adds mthi to the start cycle.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input int l,
                           input bit h, input int inj, input bit wr_same);
        logic [63:0] p;
        int          n;
        bit          fin;
        int          dc0;
        exp_t        e;
        p = longint'($signed(a)) * longint'($signed(b));
        @(negedge clock);
        op_a = a; op_b = b; start = 1'b1; lat = l; hang = h;
        exp_a = a; exp_b = b;
        if (wr_same) begin mthi = 1'b1; wdata = $urandom; end
        e.is_err = h;
        e.hi = h ? model_hi : p[63:32];
        e.lo = h ? model_lo : p[31:0];
        sbq.push_back(e);
        dc0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0; op_a = $urandom; op_b = $urandom;
        n = 1;
        @(negedge clock);
        check("init_cycle", {61'd0, mult_init, mult_run, busy}, 64'b101);
        @(posedge clock); n = 2;
        @(negedge clock);
        check("run_cycle", {62'd0, mult_init, mult_run}, 64'b01);
        fin = 1'b0;
        while (!fin && n < 100) begin
            if (done || (busy && error)) begin
                fin = 1'b1;
            end else begin
                if (n == inj) begin
                    start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF; op_a = ~a;
                end
                @(posedge clock); #1;
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
                n++;
                @(negedge clock);
            end
        end
        check("completion_latency", 64'(n), h ? 64'd50 : 64'(l + 2));
        @(negedge clock);
        check("post_state", {61'd0, busy, done, error}, {61'd0, 1'b0, 1'b0, h});
        check("done_pulses", 64'(done_cnt), 64'(dc0 + (h ? 0 : 1)));
        if (!h) begin model_hi = p[63:32]; model_lo = p[31:0]; end
        check("hilo_after", {hi_out, lo_out}, {model_hi, model_lo});
    endtask

    task automatic direct_write(input bit h, input bit l, input logic [31:0] d);
        @(negedge clock);
        mthi = h; mtlo = l; wdata = d;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (h) model_hi = d;
        if (l) model_lo = d;
        @(negedge clock);
        check("direct_write", {hi_out, lo_out}, {model_hi, model_lo});
        check("direct_write_idle", {62'd0, busy, done}, 64'd0);
    endtask

    task automatic reset_mid_run();
        int dc0;
        exp_t e;
        @(negedge clock);
        op_a = 32'd1234; op_b = 32'd99; start = 1'b1; lat = 34; hang = 1'b0;
        exp_a = 32'd1234; exp_b = 32'd99;
        e.is_err = 1'b0; e.hi = '0; e.lo = 32'd122166;
        sbq.push_back(e);
        dc0 = done_cnt;
        @(posedge clock); #1 start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        void'(sbq.pop_back());
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("reset_mid_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_mid_ab", {mult_a, mult_b}, 64'd0);
        check("reset_mid_ctl", {59'd0, mult_init, mult_run, busy, done, error}, 64'd0);
        model_hi = '0; model_lo = '0;
        repeat (45) @(negedge clock);
        check("reset_mid_no_done", 64'(done_cnt), 64'(dc0));
        check("reset_mid_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int l;
        int inj;
        bit h;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_ab", {mult_a, mult_b}, 64'd0);
        check("reset_ctl", {59'd0, mult_init, mult_run, busy, done, error}, 64'd0);
        reset = 1'b0;
        fork
            monitor();
        join_none

        do_mult(32'd6, 32'd7, 34, 1'b0, 0, 1'b0);
        check("basic_6x7", {hi_out, lo_out}, 64'h00000000_0000002A);
        do_mult(32'hFFFFFFFD, 32'd5, 34, 1'b0, 0, 1'b0);
        check("signed_neg3x5", {31'd0, error, hi_out, lo_out}, {32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1});
        do_mult(32'h00012345, 32'h00000100, 34, 1'b0, 12, 1'b0);
        do_mult(32'hCAFEF00D, 32'h00000003, 20, 1'b1, 0, 1'b0);
        check("timeout_error", 64'(error), 64'd1);
        @(negedge clock);
        op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        exp_a = 32'd3; exp_b = 32'd3; lat = 5; hang = 1'b0;
        sbq.push_back('{is_err: 1'b0, hi: 32'd0, lo: 32'd9});
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        check("error_cleared_on_start", 64'(error), 64'd0);
        wait (busy == 1'b0 || $time > 64'd100000);
        @(negedge clock);
        model_hi = 32'd0; model_lo = 32'd9;
        check("after_clear_run", {hi_out, lo_out}, 64'd9);
        reset_mid_run();
        direct_write(1'b1, 1'b1, 32'h12345678);
        direct_write(1'b1, 1'b0, 32'hA5A5A5A5);
        direct_write(1'b0, 1'b1, 32'h5A5A5A5A);
        do_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 48, 1'b0, 0, 1'b1);
        do_mult(32'h80000000, 32'hFFFFFFFF, 1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0)
                direct_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            l   = $urandom_range(1, 48);
            h   = ($urandom_range(0, 7) == 0);
            inj = $urandom_range(0, 1) ? $urandom_range(3, l + 1) : 0;
            do_mult($urandom, $urandom, l, h, inj, 1'($urandom_range(0, 1)) & !h);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
